// File: rtl/status_cond_if.sv
// Bundle between the EX/ID pipeline control and the NZCV status/condition unit.
// The pipeline drives the master side; status_cond_unit sits on the slave side.
interface status_cond_if #(
    parameter int CNT_W = 16
);
    logic [3:0]       statusIn;
    logic             sUpdate;
    logic             freeze;
    logic             flush;
    logic [3:0]       cond;
    logic             condValid;
    logic [3:0]       status;
    logic             carryOut;
    logic             condPass;
    logic             condHazard;
    logic             exCondPass;
    logic [CNT_W-1:0] squashCnt;

    modport master (
        output statusIn, sUpdate, freeze, flush, cond, condValid,
        input  status, carryOut, condPass, condHazard, exCondPass, squashCnt
    );

    modport slave (
        input  statusIn, sUpdate, freeze, flush, cond, condValid,
        output status, carryOut, condPass, condHazard, exCondPass, squashCnt
    );
endinterface

// File: rtl/status_cond_unit.sv
// Architectural NZCV register, ARM condition evaluation for the ID instruction,
// and the registered ID/EX pass bit plus a squashed-instruction counter.
module status_cond_unit #(
    parameter int BYPASS = 1,
    parameter int CNT_W  = 16
) (
    input  logic          clk,
    input  logic          rst,
    status_cond_if.slave  bus
);

    logic [3:0]       status_p1;
    logic             ex_pass_p1;
    logic [CNT_W-1:0] squash_cnt_p1;

    logic [3:0]       flags_eff;
    logic             pass_p0;
    logic             hazard_p0;

    // Flag order is {N,Z,C,V}.
    function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, r;
        n  = f[3];
        z  = f[2];
        cy = f[1];
        v  = f[0];
        r  = 1'b0;
        case (c)
            4'b0000: r = z;
            4'b0001: r = !z;
            4'b0010: r = cy;
            4'b0011: r = !cy;
            4'b0100: r = n;
            4'b0101: r = !n;
            4'b0110: r = v;
            4'b0111: r = !v;
            4'b1000: r = cy & !z;
            4'b1001: r = !cy | z;
            4'b1010: r = (n == v);
            4'b1011: r = (n != v);
            4'b1100: r = !z & (n == v);
            4'b1101: r = z | (n != v);
            4'b1110: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // ID stage: the in-flight EX result wins over the stored flags when bypassing.
    always_comb begin
        flags_eff = status_p1;
        hazard_p0 = 1'b0;
        if (BYPASS != 0) begin
            if (bus.sUpdate)
                flags_eff = bus.statusIn;
        end else begin
            hazard_p0 = bus.condValid & bus.sUpdate & (bus.cond != 4'b1110);
        end
        pass_p0 = bus.condValid & cond_eval(bus.cond, flags_eff);
    end

    // ID/EX boundary; freeze holds everything, flush only bubbles the ID result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_p1     <= 4'b0000;
            ex_pass_p1    <= 1'b0;
            squash_cnt_p1 <= '0;
        end else if (!bus.freeze) begin
            if (bus.sUpdate)
                status_p1 <= bus.statusIn;
            ex_pass_p1 <= (bus.flush | hazard_p0) ? 1'b0 : pass_p0;
            if (!bus.flush && !hazard_p0 && bus.condValid && !pass_p0)
                squash_cnt_p1 <= squash_cnt_p1 + CNT_W'(1);
        end
    end

    assign bus.status     = status_p1;
    assign bus.carryOut   = status_p1[1];
    assign bus.condPass   = pass_p0;
    assign bus.condHazard = hazard_p0;
    assign bus.exCondPass = ex_pass_p1;
    assign bus.squashCnt  = squash_cnt_p1;

endmodule

// File: doc/status_cond_unit.md
Name: status_cond_unit

Overview:
- Consumer end of the ALU status interface for the lab ARM-subset pipeline.
- Holds the architectural NZCV status register, loaded from the ALU 4-bit status {N,Z,C,V} when an S-flagged instruction executes.
- Evaluates the 4-bit ARM condition field of the instruction in ID against the current flags, and registers the pass/fail result into the ID/EX boundary.
- Returns the stored C flag as the ALU carryIn. Flags a condition hazard when forwarding is disabled, and counts squashed instructions.

Parameters:
- BYPASS, 1, 1 = ID condition is evaluated against statusIn when an update is in flight; 0 = stall instead via condHazard.
- CNT_W, 16, width of the squashed-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- statusIn  input  4  {N,Z,C,V} from the ALU, EX stage.
- sUpdate  input  1  EX instruction is valid and has its S bit set.
- freeze  input  1  pipeline stall; holds all registers.
- flush  input  1  branch taken; squashes the ID result.
- cond  input  4  condition field of the ID instruction.
- condValid  input  1  ID holds a valid instruction.
- status  output  4  registered NZCV.
- carryOut  output  1  status[1], the C flag, feeds ALU carryIn.
- condPass  output  1  combinational pass for the ID instruction.
- condHazard  output  1  stall request; always 0 when BYPASS=1.
- exCondPass  output  1  registered condPass, aligned with EX.
- squashCnt  output  CNT_W  count of valid, unflushed, condition-failed instructions.

Behaviour:
- Reset (async): status=0000, exCondPass=0, squashCnt=0. condHazard and condPass follow from their equations with status=0.
- Status register: on a rising edge with sUpdate=1 and freeze=0, status<=statusIn. Otherwise it holds. flush does not block the update, because the EX instruction is older than the branch.
- Effective flags F:
  - BYPASS=1: F = statusIn when sUpdate=1, else F = status.
  - BYPASS=0: F = status.
- Condition table (cond -> pass):
  - 0000 EQ: Z. 0001 NE: !Z.
  - 0010 CS: C. 0011 CC: !C.
  - 0100 MI: N. 0101 PL: !N.
  - 0110 VS: V. 0111 VC: !V.
  - 1000 HI: C&!Z. 1001 LS: !C|Z.
  - 1010 GE: N==V. 1011 LT: N!=V.
  - 1100 GT: !Z&(N==V). 1101 LE: Z|(N!=V).
  - 1110 AL: 1. 1111 NV: 0.
- condPass = condValid & table(cond, F). Combinational, zero latency.
- condHazard (BYPASS=0 only) = condValid & sUpdate & (cond != 1110).
  - While condHazard=1, the pipeline is expected to assert freeze.
  - The block does not self-freeze.
- exCondPass: on each rising edge with freeze=0:
  - flush=1 or condHazard=1 -> 0 (bubble).
  - otherwise -> condPass.
  - freeze=1 holds the value.
- squashCnt: increments by 1 on an edge where freeze=0, flush=0, condHazard=0, condValid=1 and condPass=0. It wraps from all-ones to 0.
- Simultaneous events:
  - sUpdate with cond evaluation under BYPASS=1: the new flags decide the ID instruction in the same cycle.
  - freeze with sUpdate: the update is lost. The pipeline guarantees the EX instruction is held and re-presents it.
- Reset mid-operation: all registers clear immediately, with no clock edge required.

Test Plan:
- Reset: rst=1 asynchronously mid-cycle -> status=0000, carryOut=0, exCondPass=0, squashCnt=0. With cond=0001 (NE) and condValid=1 -> condPass=1.
- Update/hold: statusIn=0110, sUpdate=1, one edge -> status=0110, carryOut=1. Then sUpdate=0, statusIn=1001, three edges -> status remains 0110. Repeat with freeze=1 -> status unchanged.
- Full condition sweep: for each status in {0000, 0100, 1000, 0001, 1001, 0010, 0110}, step cond 0000..1111 -> condPass matches the table. E.g. status=1000 (N=1, V=0): GE=0, LT=1, GT=0, LE=1, AL=1, NV=0.
- Bypass: BYPASS=1, status=0000, sUpdate=1, statusIn=0100, cond=0000 -> condPass=1 in the same cycle, exCondPass=1 after the edge.
- Same stimulus with BYPASS=0 -> condHazard=1, condPass=0, exCondPass=0 after the edge. Next cycle with sUpdate=0 -> condPass=1.
- Squash counter: six valid instructions with cond=0000 and Z=0 (one with flush=1, one with freeze=1) -> squashCnt=4.
- Wrap: with CNT_W=4, preload via 15 squashes, then one more -> squashCnt=0.
